axi4_burst_seq: RTL and testbench

AXI4_BURST_SEQ -- requirements
Module: axi4_burst_seq

---
 rtl/axi4_burst_seq.sv | 140 ++++++++++++++
 tb/tb_axi4_burst_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_seq.sv
// AXI4 burst address sequencer.
// Accepts one AW/AR-style request at a time and expands it into per-beat
// addresses for FIXED, INCR and WRAP bursts. Address arithmetic is confined
// to the low OFT_WIDTH bits (the 4 KB window); upper bits never change.
// Illegal requests are accepted, flagged with a one-cycle err_o pulse and
// dropped without producing any beats.
module axi4_burst_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int OFT_WIDTH  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ax_valid_i,
  output logic                  ax_ready_o,
  input  logic [ID_WIDTH-1:0]   ax_id_i,
  input  logic [ADDR_WIDTH-1:0] ax_addr_i,
  input  logic [7:0]            ax_len_i,
  input  logic [2:0]            ax_size_i,
  input  logic [1:0]            ax_burst_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [ID_WIDTH-1:0]   beat_id_o,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [7:0]            beat_idx_o,
  output logic                  beat_last_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  logic [0:0]            state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            idx_q;
  logic [7:0]            len_q;
  logic [1:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic                  req_fire;
  logic                  req_legal;
  logic                  last;

  // Request legality: size above 8 bytes, the reserved burst encoding and
  // WRAP lengths other than 2/4/8/16 beats are all rejected.
  function automatic logic is_legal(input logic [2:0] size,
                                    input logic [1:0] burst,
                                    input logic [7:0] len);
    logic ok;
    ok = 1'b1;
    if (size > 3'd3) ok = 1'b0;
    if (burst == BURST_RSVD) ok = 1'b0;
    if (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ok = 1'b0;
    return ok;
  endfunction

  // Next in-window offset. Work in beat units (s = off >> size); INCR bumps
  // s with wrap at the window edge, WRAP only lets the bits covered by len
  // change so the address cycles inside the aligned wrap container.
  function automatic logic [OFT_WIDTH-1:0] next_off(input logic [OFT_WIDTH-1:0] off,
                                                    input logic [1:0]           size,
                                                    input logic [7:0]           len,
                                                    input logic [1:0]           burst);
    logic [OFT_WIDTH-1:0] s;
    logic [OFT_WIDTH-1:0] s_inc;
    logic [OFT_WIDTH-1:0] ns;
    s     = off >> size;
    s_inc = s + {{(OFT_WIDTH-1){1'b0}}, 1'b1};
    ns    = s;
    if (burst == BURST_INCR) begin
      ns = s_inc;
    end else if (burst == BURST_WRAP) begin
      ns[7:0] = (len & s_inc[7:0]) | (~len & s[7:0]);
    end
    if (burst == BURST_FIXED) return off;
    return ns << size;
  endfunction

  assign req_fire     = ax_valid_i && (state == IDLE);
  assign req_legal    = is_legal(ax_size_i, ax_burst_i, ax_len_i);
  assign last         = (idx_q == len_q);

  assign ax_ready_o   = (state == IDLE);
  assign beat_valid_o = (state == BURST);
  assign busy_o       = (state == BURST);
  assign beat_last_o  = (state == BURST) && last;
  assign beat_id_o    = id_q;
  assign beat_addr_o  = addr_q;
  assign beat_idx_o   = idx_q;
  assign err_o        = err_q;

  // Control FSM plus the visible beat registers (all cleared by reset).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      id_q   <= '0;
      addr_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == IDLE) begin
        if (req_fire) begin
          id_q   <= ax_id_i;
          addr_q <= ax_addr_i;
          idx_q  <= '0;
          if (req_legal) state <= BURST;
          else           err_q <= 1'b1;
        end
      end else begin
        if (beat_ready_i) begin
          if (last) begin
            state <= IDLE;
          end else begin
            idx_q  <= idx_q + 8'd1;
            addr_q <= {addr_q[ADDR_WIDTH-1:OFT_WIDTH],
                       next_off(addr_q[OFT_WIDTH-1:0], size_q, len_q, burst_q)};
          end
        end
      end
    end
  end

  // Burst shape captured with the request; only read while in BURST.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      len_q   <= ax_len_i;
      size_q  <= ax_size_i[1:0];
      burst_q <= ax_burst_i;
    end
  end

endmodule

// File: tb/tb_axi4_burst_seq.sv
// Directed bench for axi4_burst_seq: hand-computed beat address sequences,
// back-pressure, mid-burst reset and illegal request rejection.
module tb_axi4_burst_seq;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int OW = 12;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          ax_valid_i;
  logic          ax_ready_o;
  logic [IW-1:0] ax_id_i;
  logic [AW-1:0] ax_addr_i;
  logic [7:0]    ax_len_i;
  logic [2:0]    ax_size_i;
  logic [1:0]    ax_burst_i;
  logic          beat_valid_o;
  logic          beat_ready_i;
  logic [IW-1:0] beat_id_o;
  logic [AW-1:0] beat_addr_o;
  logic [7:0]    beat_idx_o;
  logic          beat_last_o;
  logic          busy_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_addr [16];

  always #5 clk = ~clk;

  axi4_burst_seq #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .OFT_WIDTH(OW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .ax_valid_i   (ax_valid_i),
    .ax_ready_o   (ax_ready_o),
    .ax_id_i      (ax_id_i),
    .ax_addr_i    (ax_addr_i),
    .ax_len_i     (ax_len_i),
    .ax_size_i    (ax_size_i),
    .ax_burst_i   (ax_burst_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_id_o    (beat_id_o),
    .beat_addr_o  (beat_addr_o),
    .beat_idx_o   (beat_idx_o),
    .beat_last_o  (beat_last_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; it is accepted at that edge.
  task automatic send_req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    check_eq("ax_ready_before_req", ax_ready_o, 1);
    ax_valid_i = 1'b1;
    ax_id_i    = id;
    ax_addr_i  = addr;
    ax_len_i   = len;
    ax_size_i  = size;
    ax_burst_i = burst;
    tick;
    ax_valid_i = 1'b0;
    ax_addr_i  = '0;
  endtask

  // Consume beats first..n-1 with ready high, checking against exp_addr.
  task automatic run_beats(input string tag, input logic [IW-1:0] id,
                           input int first, input int n);
    beat_ready_i = 1'b1;
    for (int i = first; i < n; i++) begin
      check_eq({tag, "_valid"}, beat_valid_o, 1);
      check_eq({tag, "_busy"},  busy_o, 1);
      check_eq({tag, "_addr"},  beat_addr_o, exp_addr[i]);
      check_eq({tag, "_idx"},   beat_idx_o, i);
      check_eq({tag, "_last"},  beat_last_o, (i == n - 1));
      check_eq({tag, "_id"},    beat_id_o, id);
      tick;
    end
    check_eq({tag, "_end_valid"}, beat_valid_o, 0);
    check_eq({tag, "_end_busy"},  busy_o, 0);
    check_eq({tag, "_end_ready"}, ax_ready_o, 1);
  endtask

  // Illegal request: accepted, err pulse for exactly one cycle, no beats.
  task automatic illegal_req(input string tag, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    send_req(4'h9, 32'h0000_0200, len, size, burst);
    check_eq({tag, "_err"},   err_o, 1);
    check_eq({tag, "_valid"}, beat_valid_o, 0);
    check_eq({tag, "_busy"},  busy_o, 0);
    check_eq({tag, "_ready"}, ax_ready_o, 1);
    tick;
    check_eq({tag, "_err_off"},  err_o, 0);
    check_eq({tag, "_valid2"},   beat_valid_o, 0);
    check_eq({tag, "_busy2"},    busy_o, 0);
  endtask

  initial begin
    rst_n_i      = 1'b0;
    ax_valid_i   = 1'b0;
    ax_id_i      = '0;
    ax_addr_i    = '0;
    ax_len_i     = '0;
    ax_size_i    = '0;
    ax_burst_i   = '0;
    beat_ready_i = 1'b1;
    tick;
    tick;
    check_eq("rst_valid", beat_valid_o, 0);
    check_eq("rst_busy",  busy_o, 0);
    check_eq("rst_err",   err_o, 0);
    check_eq("rst_last",  beat_last_o, 0);
    check_eq("rst_idx",   beat_idx_o, 0);
    check_eq("rst_addr",  beat_addr_o, 0);
    check_eq("rst_id",    beat_id_o, 0);
    rst_n_i = 1'b1;
    tick;
    check_eq("rst_ready_after", ax_ready_o, 1);

    // INCR, word beats, starting mid-word-aligned
    exp_addr[0] = 32'h1000_0004; exp_addr[1] = 32'h1000_0008;
    exp_addr[2] = 32'h1000_000C; exp_addr[3] = 32'h1000_0010;
    send_req(4'h5, 32'h1000_0004, 8'd3, 3'd2, 2'b01);
    run_beats("incr4", 4'h5, 0, 4);

    // WRAP 4 x 4 bytes starting at the top of its 16-byte container
    exp_addr[0] = 32'h0000_001C; exp_addr[1] = 32'h0000_0010;
    exp_addr[2] = 32'h0000_0014; exp_addr[3] = 32'h0000_0018;
    send_req(4'h3, 32'h0000_001C, 8'd3, 3'd2, 2'b10);
    run_beats("wrap4", 4'h3, 0, 4);

    // WRAP 8 x 8 bytes inside a 64-byte container at 0x100
    exp_addr[0] = 32'h0000_0128; exp_addr[1] = 32'h0000_0130;
    exp_addr[2] = 32'h0000_0138; exp_addr[3] = 32'h0000_0100;
    exp_addr[4] = 32'h0000_0108; exp_addr[5] = 32'h0000_0110;
    exp_addr[6] = 32'h0000_0118; exp_addr[7] = 32'h0000_0120;
    send_req(4'hA, 32'h0000_0128, 8'd7, 3'd3, 2'b10);
    run_beats("wrap8", 4'hA, 0, 8);

    // FIXED: same address every beat
    exp_addr[0] = 32'h0000_0040; exp_addr[1] = 32'h0000_0040;
    exp_addr[2] = 32'h0000_0040;
    send_req(4'h1, 32'h0000_0040, 8'd2, 3'd3, 2'b00);
    run_beats("fixed", 4'h1, 0, 3);

    // INCR from an unaligned address aligns on beat 1
    exp_addr[0] = 32'h0000_0003; exp_addr[1] = 32'h0000_0004;
    send_req(4'h2, 32'h0000_0003, 8'd1, 3'd2, 2'b01);
    run_beats("unalign", 4'h2, 0, 2);

    // INCR byte beats crossing the 4 KB window edge wraps, no carry up
    exp_addr[0] = 32'h1000_0FFE; exp_addr[1] = 32'h1000_0FFF;
    exp_addr[2] = 32'h1000_0000; exp_addr[3] = 32'h1000_0001;
    send_req(4'h7, 32'h1000_0FFE, 8'd3, 3'd0, 2'b01);
    run_beats("win4k", 4'h7, 0, 4);

    // Back-pressure on beat 1 for three cycles
    exp_addr[0] = 32'h2000_0100; exp_addr[1] = 32'h2000_0104;
    exp_addr[2] = 32'h2000_0108; exp_addr[3] = 32'h2000_010C;
    send_req(4'h4, 32'h2000_0100, 8'd3, 3'd2, 2'b01);
    check_eq("stall_b0_addr", beat_addr_o, 32'h2000_0100);
    tick;
    beat_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("stall_valid", beat_valid_o, 1);
      check_eq("stall_addr",  beat_addr_o, 32'h2000_0104);
      check_eq("stall_idx",   beat_idx_o, 1);
      check_eq("stall_last",  beat_last_o, 0);
      check_eq("stall_id",    beat_id_o, 4'h4);
      tick;
    end
    run_beats("stall", 4'h4, 1, 4);

    // Reset mid-burst abandons the burst
    send_req(4'h6, 32'h3000_0000, 8'd7, 3'd2, 2'b01);
    tick;
    check_eq("mrst_b1_addr", beat_addr_o, 32'h3000_0004);
    rst_n_i = 1'b0;
    tick;
    check_eq("mrst_valid", beat_valid_o, 0);
    check_eq("mrst_busy",  busy_o, 0);
    check_eq("mrst_addr",  beat_addr_o, 0);
    check_eq("mrst_idx",   beat_idx_o, 0);
    check_eq("mrst_id",    beat_id_o, 0);
    check_eq("mrst_last",  beat_last_o, 0);
    rst_n_i = 1'b1;
    tick;
    check_eq("mrst_ready", ax_ready_o, 1);
    check_eq("mrst_valid_after", beat_valid_o, 0);
    tick;
    check_eq("mrst_valid_idle", beat_valid_o, 0);

    // Illegal requests
    illegal_req("ill_rsvd",  8'd3, 3'd2, 2'b11);
    illegal_req("ill_wrap2", 8'd2, 3'd2, 2'b10);
    illegal_req("ill_size",  8'd0, 3'd4, 2'b01);

    // Recovery: legal burst still works after rejections
    exp_addr[0] = 32'h0000_0800; exp_addr[1] = 32'h0000_0802;
    send_req(4'hF, 32'h0000_0800, 8'd1, 3'd1, 2'b01);
    check_eq("post_ill_err", err_o, 0);
    run_beats("post_ill", 4'hF, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
